// File: rtl/updown_sweep_controller_if.sv
// Config/command and status bundle between a sweep controller and its control logic.
// master drives commands and limits; slave (the controller) drives count and status.
interface updown_sweep_controller_if #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   lo_limit;
    logic [WIDTH-1:0]   hi_limit;
    logic [DWELL_W-1:0] dwell;
    logic [SWEEP_W-1:0] num_sweeps;
    logic [WIDTH-1:0]   count;
    logic               up_down;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic [2:0]         state;

    modport master (
        output start, stop, lo_limit, hi_limit, dwell, num_sweeps,
        input  count, up_down, busy, done, cfg_err, state
    );

    modport slave (
        input  start, stop, lo_limit, hi_limit, dwell, num_sweeps,
        output count, up_down, busy, done, cfg_err, state
    );
endinterface

// File: rtl/updown_sweep_controller.sv
// Bounded triangle-sweep sequencer: lo..hi..lo with dwell at each bound, repeated num_sweeps times.
// All outputs registered; count reaches hi hi-lo edges after start; no backpressure, stop aborts next edge.
module updown_sweep_controller #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    updown_sweep_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UP       = 3'd1,
        S_DWELL_HI = 3'd2,
        S_DOWN     = 3'd3,
        S_DWELL_LO = 3'd4
    } state_e;

    localparam logic [WIDTH-1:0]   C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] D_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0] S_ONE = {{(SWEEP_W-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt_q;
    logic [SWEEP_W-1:0] nsweep_q;
    logic [SWEEP_W-1:0] sweep_q;
    logic               up_down_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic [WIDTH-1:0]   count_inc;
    logic [WIDTH-1:0]   count_dec;
    logic [SWEEP_W-1:0] sweep_inc;
    logic [DWELL_W-1:0] dwell_last;
    logic               cfg_bad;

    // Only computed from registered values that stay in [lo,hi]; the bound checks
    // below stop the count before the increment/decrement could ever wrap.
    assign count_inc  = count_q + C_ONE;
    assign count_dec  = count_q - C_ONE;
    assign sweep_inc  = sweep_q + S_ONE;
    assign dwell_last = dwell_q - D_ONE;
    assign cfg_bad    = (bus.lo_limit >= bus.hi_limit) || (bus.num_sweeps == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            dcnt_q    <= '0;
            nsweep_q  <= '0;
            sweep_q   <= '0;
            up_down_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q != S_IDLE && bus.stop) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                up_down_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            lo_q     <= bus.lo_limit;
                            hi_q     <= bus.hi_limit;
                            dwell_q  <= bus.dwell;
                            nsweep_q <= bus.num_sweeps;
                            if (cfg_bad) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                count_q   <= bus.lo_limit;
                                up_down_q <= 1'b1;
                                busy_q    <= 1'b1;
                                sweep_q   <= '0;
                                state_q   <= S_UP;
                            end
                        end
                    end
                    S_UP: begin
                        count_q <= count_inc;
                        if (count_inc == hi_q) begin
                            up_down_q <= 1'b0;
                            dcnt_q    <= '0;
                            state_q   <= (dwell_q != '0) ? S_DWELL_HI : S_DOWN;
                        end
                    end
                    S_DWELL_HI: begin
                        if (dcnt_q == dwell_last) begin
                            state_q <= S_DOWN;
                        end else begin
                            dcnt_q <= dcnt_q + D_ONE;
                        end
                    end
                    S_DOWN: begin
                        count_q <= count_dec;
                        if (count_dec == lo_q) begin
                            sweep_q <= sweep_inc;
                            // Completion skips the low dwell; up_down is left at 0.
                            if (sweep_inc == nsweep_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                up_down_q <= 1'b1;
                                dcnt_q    <= '0;
                                state_q   <= (dwell_q != '0) ? S_DWELL_LO : S_UP;
                            end
                        end
                    end
                    S_DWELL_LO: begin
                        if (dcnt_q == dwell_last) begin
                            state_q <= S_UP;
                        end else begin
                            dcnt_q <= dcnt_q + D_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.up_down = up_down_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: expected per-cycle outputs are built as a trace from the
// sweep rules (lo..hi..lo with dwell holds) and compared cycle by cycle at the falling edge.
module tb_updown_sweep_controller;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UP   = 3'd1;
    localparam logic [2:0] ST_DHI  = 3'd2;
    localparam logic [2:0] ST_DOWN = 3'd3;
    localparam logic [2:0] ST_DLO  = 3'd4;

    typedef struct packed {
        logic [3:0] count;
        logic       up_down;
        logic       busy;
        logic       done;
        logic       cfg_err;
        logic [2:0] state;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_id  = 0;

    logic [3:0] m_count = 4'd0;
    logic       m_ud    = 1'b0;
    obs_t       exp_q[$];

    updown_sweep_controller_if #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(8)) bus ();

    updown_sweep_controller #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.count   = bus.count;
        o.up_down = bus.up_down;
        o.busy    = bus.busy;
        o.done    = bus.done;
        o.cfg_err = bus.cfg_err;
        o.state   = bus.state;
        return o;
    endfunction

    function automatic obs_t mk(input int c, input bit ud, input bit b, input bit dn,
                                input bit ce, input logic [2:0] st);
        obs_t o;
        o.count   = 4'(c);
        o.up_down = ud;
        o.busy    = b;
        o.done    = dn;
        o.cfg_err = ce;
        o.state   = st;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d ud=%b busy=%b done=%b err=%b st=%0d, expected cnt=%0d ud=%b busy=%b done=%b err=%b st=%0d",
                     tag, got.count, got.up_down, got.busy, got.done, got.cfg_err, got.state,
                     exp.count, exp.up_down, exp.busy, exp.done, exp.cfg_err, exp.state);
        end
    endtask

    // Expected outputs for every cycle after the accepted start edge, through one idle cycle after done.
    task automatic build_trace(input int lo, input int hi, input int d, input int ns);
        exp_q.delete();
        for (int s = 0; s < ns; s++) begin
            if (s > 0) for (int k = 0; k < d; k++) exp_q.push_back(mk(lo, 1, 1, 0, 0, ST_DLO));
            for (int c = lo; c < hi; c++) exp_q.push_back(mk(c, 1, 1, 0, 0, ST_UP));
            for (int k = 0; k < d; k++) exp_q.push_back(mk(hi, 0, 1, 0, 0, ST_DHI));
            exp_q.push_back(mk(hi, 0, 1, 0, 0, ST_DOWN));
            for (int c = hi - 1; c > lo; c--) exp_q.push_back(mk(c, 0, 1, 0, 0, ST_DOWN));
        end
        exp_q.push_back(mk(lo, 0, 0, 1, 0, ST_IDLE));
        exp_q.push_back(mk(lo, 0, 0, 0, 0, ST_IDLE));
    endtask

    task automatic scramble();
        bus.lo_limit   = 4'($urandom_range(15));
        bus.hi_limit   = 4'($urandom_range(15));
        bus.dwell      = 4'($urandom_range(15));
        bus.num_sweeps = 8'($urandom_range(255));
    endtask

    task automatic run_cfg(input int lo, input int hi, input int d, input int ns,
                           input int stop_at, input bit poke);
        int n;
        run_id++;
        bus.lo_limit   = 4'(lo);
        bus.hi_limit   = 4'(hi);
        bus.dwell      = 4'(d);
        bus.num_sweeps = 8'(ns);
        bus.stop       = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke) scramble();
        if (lo >= hi || ns == 0) begin
            check($sformatf("run%0d_cfg_err", run_id), sample(), mk(m_count, m_ud, 0, 0, 1, ST_IDLE));
            @(negedge clk);
            check($sformatf("run%0d_cfg_clr", run_id), sample(), mk(m_count, m_ud, 0, 0, 0, ST_IDLE));
            return;
        end
        build_trace(lo, hi, d, ns);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("run%0d_cyc%0d", run_id, i), sample(), exp_q[i]);
            if (i == stop_at && exp_q[i].state != ST_IDLE) begin
                bus.stop = 1'b1;
                @(negedge clk);
                bus.stop = 1'b0;
                m_count  = exp_q[i].count;
                m_ud     = 1'b0;
                check($sformatf("run%0d_stop", run_id), sample(), mk(m_count, 0, 0, 0, 0, ST_IDLE));
                @(negedge clk);
                check($sformatf("run%0d_stop_hold", run_id), sample(), mk(m_count, 0, 0, 0, 0, ST_IDLE));
                return;
            end
            if (i < n - 1) begin
                if (poke && exp_q[i].state != ST_IDLE) begin
                    bus.start = 1'($urandom_range(1));
                    scramble();
                end
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        m_count = 4'(lo);
        m_ud    = 1'b0;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.lo_limit   = 4'd0;
        bus.hi_limit   = 4'd0;
        bus.dwell      = 4'd0;
        bus.num_sweeps = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_state", sample(), mk(0, 0, 0, 0, 0, ST_IDLE));
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", sample(), mk(0, 0, 0, 0, 0, ST_IDLE));

        run_cfg(2, 5, 0, 1, -1, 1'b0);
        run_cfg(2, 5, 2, 2, -1, 1'b1);
        run_cfg(0, 15, 0, 1, -1, 1'b0);
        run_cfg(7, 7, 1, 1, -1, 1'b0);
        run_cfg(2, 5, 1, 0, -1, 1'b0);
        run_cfg(14, 15, 3, 2, -1, 1'b1);
        // Index 6 of this trace is count=4 on the way down.
        run_cfg(2, 6, 0, 1, 6, 1'b0);
        run_cfg(1, 3, 1, 1, -1, 1'b1);

        bus.lo_limit   = 4'd1;
        bus.hi_limit   = 4'd8;
        bus.num_sweeps = 8'd1;
        bus.start      = 1'b1;
        bus.stop       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_idle", sample(), mk(m_count, m_ud, 0, 0, 0, ST_IDLE));

        bus.lo_limit   = 4'd2;
        bus.hi_limit   = 4'd9;
        bus.dwell      = 4'd0;
        bus.num_sweeps = 8'd1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        build_trace(2, 9, 0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pre_reset_cyc%0d", i), sample(), exp_q[i]);
            if (i < 3) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 check("async_reset", sample(), mk(0, 0, 0, 0, 0, ST_IDLE));
        @(negedge clk);
        check("reset_held", sample(), mk(0, 0, 0, 0, 0, ST_IDLE));
        reset   = 1'b1;
        m_count = 4'd0;
        m_ud    = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            int lo, hi, d, ns, sa;
            lo = $urandom_range(15);
            hi = ($urandom_range(5) == 0) ? $urandom_range(15) : lo + 1 + $urandom_range(14 - ((lo > 14) ? 14 : lo));
            if (hi > 15) hi = 15;
            d  = ($urandom_range(4) == 0) ? 15 : $urandom_range(3);
            ns = $urandom_range(3);
            sa = ($urandom_range(3) == 0) ? $urandom_range(60) : -1;
            run_cfg(lo, hi, d, ns, sa, 1'b1);
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
